postprocess_module: RTL
=======================

// Module: postprocess_module
// PURPOSE
//  Write-back end of the filter pipeline: collects 8-bit results from the 3x3 core
//  (one per core_en cycle), packs 4 pixels per 32-bit word and drains them through
//  a word FIFO to the memory controller with a req/ack write handshake.
//  Sits between core and memory controller; reports frame completion to the controller.
// PARAMETERS
//  MAX_ROW     540  input image rows; output rows = MAX_ROW-2
//  MAX_COL     540  input image cols; output pixels/row = MAX_COL-2
//  FIFO_DEPTH  16   word FIFO entries (power of 2, >=4)
//  ADDR_W      20   word address width
//  BASE_ADDR   0    first word address of output frame
// PORTS
//  clk          in   1       system clock
//  rst_n        in   1       asynchronous active-low reset
//  start_i      in   1       controller: start frame (1-cycle pulse, IDLE only)
//  result_i     in   8       core: filtered pixel
//  result_en_i  in   1       core: result_i valid this cycle
//  stall_o      out  1       to controller: pause core_run (FIFO almost full)
//  wr_req_o     out  1       to mem ctrl: write request
//  wr_addr_o    out  ADDR_W  to mem ctrl: word address
//  wr_data_o    out  32      to mem ctrl: packed word, first pixel in [7:0]
//  wr_ack_i     in   1       from mem ctrl: word accepted this cycle
//  frame_done_o out  1       to controller: 1-cycle pulse, frame fully written
//  overflow_o   out  1       sticky: word dropped on full FIFO
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, FIFO empty, counters 0, wr_addr_o=BASE_ADDR.
//  - FSM IDLE -> RUN on start_i (clears counters, overflow_o, addr=BASE_ADDR).
//    RUN -> FLUSH when last pixel of last output row accepted.
//    FLUSH -> DONE when FIFO empty and no pending wr_req_o. DONE -> IDLE next cycle,
//    frame_done_o=1 only in DONE. start_i outside IDLE ignored.
//  - result_en_i only counted in RUN; ignored in other states.
//  - Packing: byte lane = col_cnt[1:0]; word pushed the cycle its 4th byte (or last
//    pixel of row) arrives; pixel-to-FIFO latency 1 cycle.
//  - Row end: MAX_COL-2 not multiple of 4 -> last word of row pushed early,
//    unused upper lanes zero; next row starts at lane 0 of a new word.
//    Words/row = ceil((MAX_COL-2)/4); addresses contiguous across rows.
//  - col_cnt wraps 0..MAX_COL-3; row_cnt increments on wrap, 0..MAX_ROW-3.
//  - Handshake: wr_req_o = FIFO non-empty; wr_data_o = FIFO head (registered),
//    stable while wr_req_o && !wr_ack_i. Transfer on wr_req_o && wr_ack_i:
//    pop, wr_addr_o += 1. wr_ack_i without wr_req_o ignored.
//  - Simultaneous push+pop: count unchanged; push+pop on full FIFO allowed.
//  - stall_o = (count >= FIFO_DEPTH-2), combinational from count; 2-entry margin
//    covers core pipeline skid.
//  - Push on full FIFO without pop: word dropped, overflow_o set until next start_i.
//  - Reset mid-frame: immediate return to reset state; wr_req_o drops asynchronously.
// CONFIGURATION
//  POST_PERF_CNT_EN defined: adds output stall_cycles_o[31:0], counts cycles with
//   wr_req_o && !wr_ack_i during RUN/FLUSH, cleared on start_i, saturates at max.
//  Not defined: port and counter absent; all other behaviour identical.
// TESTING
//  1 MAX_COL=10,MAX_ROW=4: start, 16 px 01..10h, ack always 1 -> 4 words at
//    BASE..BASE+3, word0=0x04030201, frame_done_o 1 cycle after last ack.
//  2 MAX_COL=8,MAX_ROW=3: px 01..06 -> 0x04030201, 0x00000605; 2 words, done pulse.
//  3 FIFO_DEPTH=4, ack low 20 cycles, core obeys stall -> stall_o=1 at count 2,
//    wr_data_o stable, overflow_o=0, all words later written in order.
//  4 FIFO_DEPTH=4, ack low, core ignores stall -> overflow_o=1 sticky, cleared by start_i.
//  5 rst_n low mid-frame -> outputs 0 at once; new start writes from BASE_ADDR.
//  6 POST_PERF_CNT_EN: ack low exactly 7 cycles with req high -> stall_cycles_o=7.

Source files
------------

// File: rtl/postprocess_module.sv
// Write-back stage: packs 8-bit core results into 32-bit words, buffers them in a
// word FIFO and drains them to the memory controller. Optional macro: POST_PERF_CNT_EN.
module postprocess_module #(
  parameter int unsigned MAX_ROW    = 540,
  parameter int unsigned MAX_COL    = 540,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ADDR_W     = 20,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [7:0]        result_i,
  input  logic              result_en_i,
  output logic              stall_o,
  output logic              wr_req_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [31:0]       wr_data_o,
  input  logic              wr_ack_i,
  output logic              frame_done_o,
  output logic              overflow_o
`ifdef POST_PERF_CNT_EN
  ,output logic [31:0]      stall_cycles_o
`endif
);

  localparam int unsigned COL_W = (MAX_COL > 4) ? $clog2(MAX_COL) : 2;
  localparam int unsigned ROW_W = (MAX_ROW > 2) ? $clog2(MAX_ROW) : 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t             state_q;
  logic [COL_W-1:0]   col_cnt_q;
  logic [ROW_W-1:0]   row_cnt_q;
  logic [31:0]        pack_q;
  logic [31:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;

  logic               start_c;
  logic               accept_c;
  logic               col_last_c;
  logic               row_last_c;
  logic [1:0]         lane_c;
  logic [31:0]        word_c;
  logic               push_c;
  logic               pop_c;
  logic               full_c;
  logic               wr_en_c;
  logic               drop_c;
  logic [CNT_W-1:0]   count_nxt_c;

  assign start_c    = (state_q == ST_IDLE) && start_i;
  assign accept_c   = (state_q == ST_RUN) && result_en_i;
  assign col_last_c = (col_cnt_q == COL_W'(MAX_COL - 3));
  assign row_last_c = (row_cnt_q == ROW_W'(MAX_ROW - 3));
  assign lane_c     = col_cnt_q[1:0];

  // Current partial word with the incoming pixel merged into its lane
  always_comb begin
    word_c = pack_q;
    word_c[{lane_c, 3'b000} +: 8] = result_i;
  end

  // A word leaves the packer on its 4th byte or at row end (upper lanes stay zero)
  assign push_c  = accept_c && ((lane_c == 2'd3) || col_last_c);
  assign pop_c   = wr_req_o && wr_ack_i;
  assign full_c  = (count_q == CNT_W'(FIFO_DEPTH));
  assign wr_en_c = push_c && (!full_c || pop_c);
  assign drop_c  = push_c && full_c && !pop_c;

  always_comb begin
    count_nxt_c = count_q;
    case ({wr_en_c, pop_c})
      2'b10:   count_nxt_c = count_q + CNT_W'(1);
      2'b01:   count_nxt_c = count_q - CNT_W'(1);
      default: count_nxt_c = count_q;
    endcase
  end

  // Almost-full leaves two entries of headroom for words already in the core pipe
  assign stall_o   = (count_q >= CNT_W'(FIFO_DEPTH - 2));
  assign wr_data_o = mem_q[rd_ptr_q];

  // Frame sequencing, pixel counters and packer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      col_cnt_q    <= '0;
      row_cnt_q    <= '0;
      pack_q       <= '0;
      overflow_o   <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q    <= ST_RUN;
            col_cnt_q  <= '0;
            row_cnt_q  <= '0;
            pack_q     <= '0;
            overflow_o <= 1'b0;
          end
        end
        ST_RUN: begin
          if (result_en_i) begin
            pack_q <= push_c ? 32'd0 : word_c;
            if (col_last_c) begin
              col_cnt_q <= '0;
              if (row_last_c) begin
                row_cnt_q <= '0;
                state_q   <= ST_FLUSH;
              end else begin
                row_cnt_q <= row_cnt_q + ROW_W'(1);
              end
            end else begin
              col_cnt_q <= col_cnt_q + COL_W'(1);
            end
          end
        end
        ST_FLUSH: begin
          if (!wr_req_o) begin
            state_q      <= ST_DONE;
            frame_done_o <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
      if (drop_c) begin
        overflow_o <= 1'b1;
      end
    end
  end

  // Word FIFO and write address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      wr_req_o  <= 1'b0;
      wr_addr_o <= ADDR_W'(BASE_ADDR);
    end else begin
      if (wr_en_c) begin
        mem_q[wr_ptr_q] <= word_c;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (start_c) begin
        wr_addr_o <= ADDR_W'(BASE_ADDR);
      end else if (pop_c) begin
        wr_addr_o <= wr_addr_o + ADDR_W'(1);
      end
      count_q  <= count_nxt_c;
      wr_req_o <= (count_nxt_c != '0);
    end
  end

`ifdef POST_PERF_CNT_EN
  // Back-pressure cycles seen by the write port during a frame, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_o <= '0;
    end else if (start_c) begin
      stall_cycles_o <= '0;
    end else if (((state_q == ST_RUN) || (state_q == ST_FLUSH)) &&
                 wr_req_o && !wr_ack_i && (stall_cycles_o != 32'hFFFF_FFFF)) begin
      stall_cycles_o <= stall_cycles_o + 32'd1;
    end
  end
`endif

endmodule
